// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready/data, downstream
// valid/ready/data, flush and occupancy. The stage itself uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [1:0]           count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with valid/ready handshake over NCH x WIDTH channels.
// Define PIPE_STAGE_REG_SKID_EN to add a skid register (registered in_ready, full throughput).
module pipe_stage_reg #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1
  } state_t;
`endif

  state_t state_reg;
  state_t state_next;

  logic in_ready_w;
  logic out_valid_w;
  logic in_xfer;
  logic out_xfer;
  logic m_load_in;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic m_load_s;
  logic s_load;
  logic in_ready_reg;
`endif

  wire [NCH*WIDTH-1:0] out_pack;

  assign out_valid_w = (state_reg != ST_EMPTY);
  assign in_xfer     = bus.in_valid && in_ready_w;
  assign out_xfer    = out_valid_w && bus.out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  // Registered from the next state so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_reg <= 1'b1;
    end else begin
      in_ready_reg <= (state_next != ST_TWO);
    end
  end
  assign in_ready_w = in_ready_reg;
`else
  assign in_ready_w = !out_valid_w || bus.out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_load_in  = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
    m_load_s   = 1'b0;
    s_load     = 1'b0;
`endif
    if (bus.flush) begin
      // Flush wins; an entry accepted this cycle is simply not stored.
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_next = ST_ONE;
            m_load_in  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_load_in = 1'b1;
          end else if (out_xfer) begin
            state_next = ST_EMPTY;
`ifdef PIPE_STAGE_REG_SKID_EN
          end else if (in_xfer) begin
            state_next = ST_TWO;
            s_load     = 1'b1;
`endif
          end
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        ST_TWO: begin
          if (out_xfer) begin
            state_next = ST_ONE;
            m_load_s   = 1'b1;
          end
        end
`endif
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // All channels share the same load strobes; there is no per-channel enable.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] in_ch;
      logic [WIDTH-1:0] m_reg;
      logic [WIDTH-1:0] m_next;
`ifdef PIPE_STAGE_REG_SKID_EN
      logic [WIDTH-1:0] s_reg;
      logic [WIDTH-1:0] s_next;
`endif

      assign in_ch = bus.in_data[gi*WIDTH +: WIDTH];

      always_comb begin
        m_next = m_reg;
`ifdef PIPE_STAGE_REG_SKID_EN
        s_next = s_reg;
        if (s_load) begin
          s_next = in_ch;
        end
        if (m_load_s) begin
          m_next = s_reg;
        end
`endif
        if (m_load_in) begin
          m_next = in_ch;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_reg <= '0;
        end else begin
          m_reg <= m_next;
        end
      end

`ifdef PIPE_STAGE_REG_SKID_EN
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_reg <= '0;
        end else begin
          s_reg <= s_next;
        end
      end
`endif

      assign out_pack[gi*WIDTH +: WIDTH] = m_reg;
    end
  endgenerate

  always_comb begin
    case (state_reg)
      ST_ONE:  bus.count = 2'd1;
`ifdef PIPE_STAGE_REG_SKID_EN
      ST_TWO:  bus.count = 2'd2;
`endif
      default: bus.count = 2'd0;
    endcase
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_pack;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg (WIDTH=16, NCH=2); expectations
// follow PIPE_STAGE_REG_SKID_EN so the same file covers both builds.
module tb_pipe_stage_reg;
  localparam int WIDTH = 16;
  localparam int NCH   = 2;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_cnt;
    logic        chk_d;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t tbl[$];

  pipe_stage_reg_if #(.WIDTH(WIDTH), .NCH(NCH)) bus_if ();

  pipe_stage_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] d, logic ordy,
                              logic e_rdy, logic e_ov, logic [31:0] e_od,
                              logic [1:0] e_cnt, logic chk_d);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.chk_d = chk_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    bus_if.flush     = fl;
    bus_if.in_valid  = iv;
    bus_if.in_data   = d;
    bus_if.out_ready = ordy;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Expected-value table: fl iv data ordy | in_ready(pre-edge) | out_valid out_data count(post-edge) chk_data
    tbl.push_back(mk(0, 1, 32'h1234ABCD, 1, 1, 1, 32'h1234ABCD, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h00000001, 1, 1, 1, 32'h00000001, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h00000002, 1, 1, 1, 32'h00000002, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h00000003, 1, 1, 1, 32'h00000003, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h00000004, 1, 1, 1, 32'h00000004, 2'd1, 1));
    tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 0, 32'h00000004, 2'd0, 1));
`ifdef PIPE_STAGE_REG_SKID_EN
    tbl.push_back(mk(0, 1, 32'h00000005, 0, 1, 1, 32'h00000005, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h00000006, 0, 1, 1, 32'h00000005, 2'd2, 1));
    tbl.push_back(mk(0, 1, 32'h00000007, 0, 0, 1, 32'h00000005, 2'd2, 1));
    tbl.push_back(mk(0, 1, 32'h00000007, 1, 0, 1, 32'h00000006, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h00000007, 1, 1, 1, 32'h00000007, 2'd1, 1));
    tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 0, 32'h00000007, 2'd0, 1));
    tbl.push_back(mk(0, 1, 32'h000000B1, 0, 1, 1, 32'h000000B1, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h000000B2, 0, 1, 1, 32'h000000B1, 2'd2, 1));
    tbl.push_back(mk(1, 1, 32'h00000009, 0, 0, 0, 32'h00000000, 2'd0, 0));
`else
    tbl.push_back(mk(0, 1, 32'h000000A1, 1, 1, 1, 32'h000000A1, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h000000A2, 0, 0, 1, 32'h000000A1, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h000000A2, 1, 1, 1, 32'h000000A2, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h000000A3, 0, 0, 1, 32'h000000A2, 2'd1, 1));
    tbl.push_back(mk(0, 1, 32'h000000A3, 1, 1, 1, 32'h000000A3, 2'd1, 1));
    tbl.push_back(mk(0, 0, 32'h00000000, 0, 0, 1, 32'h000000A3, 2'd1, 1));
    tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 0, 32'h000000A3, 2'd0, 1));
    tbl.push_back(mk(0, 1, 32'h000000B1, 0, 1, 1, 32'h000000B1, 2'd1, 1));
    tbl.push_back(mk(1, 1, 32'h00000009, 0, 0, 0, 32'h00000000, 2'd0, 0));
`endif
    tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 0, 32'h00000000, 2'd0, 0));
    tbl.push_back(mk(1, 1, 32'h00000009, 1, 1, 0, 32'h00000000, 2'd0, 0));
    tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 0, 32'h00000000, 2'd0, 0));

    // Reset state, sampled between edges while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("reset_count", {30'd0, bus_if.count}, 32'd0);
    chk("reset_out_data", bus_if.out_data, 32'h0);
    chk("reset_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, bus_if.in_ready}, {31'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, bus_if.out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("v%0d_count", i), {30'd0, bus_if.count}, {30'd0, tbl[i].e_cnt});
      if (tbl[i].chk_d) begin
        chk($sformatf("v%0d_out_data", i), bus_if.out_data, tbl[i].e_od);
      end
      $display("vec %0d fl=%0b iv=%0b d=%h ordy=%0b -> ov=%0b od=%h cnt=%0d",
               i, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy,
               bus_if.out_valid, bus_if.out_data, bus_if.count);
    end

    // Asynchronous reset mid-stream with the stage full, then a lone new entry.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h000000C1, 1'b0);
    @(posedge clk);
    #1;
`ifdef PIPE_STAGE_REG_SKID_EN
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h000000C2, 1'b0);
    @(posedge clk);
    #1;
    chk("full_before_rst_count", {30'd0, bus_if.count}, 32'd2);
`else
    chk("full_before_rst_count", {30'd0, bus_if.count}, 32'd1);
`endif
    chk("full_before_rst_data", bus_if.out_data, 32'h000000C1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("async_rst_count", {30'd0, bus_if.count}, 32'd0);
    chk("async_rst_out_data", bus_if.out_data, 32'h0);
    chk("async_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    $display("async reset applied mid-stream: ov=%0b cnt=%0d", bus_if.out_valid, bus_if.count);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h00000042, 1'b0);
    #1;
    chk("post_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
    chk("post_rst_out_data", bus_if.out_data, 32'h00000042);
    chk("post_rst_count", {30'd0, bus_if.count}, 32'd1);
    $display("post-reset entry: ov=%0b od=%h cnt=%0d", bus_if.out_valid, bus_if.out_data, bus_if.count);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("post_rst_drain_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("post_rst_drain_count", {30'd0, bus_if.count}, 32'd0);
    $display("post-reset drain: ov=%0b cnt=%0d", bus_if.out_valid, bus_if.count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 16, bits per channel; legal range 1..64.
REQ-002 Parameter NCH, default 2, number of parallel data channels sharing one handshake; legal range 1..8.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts; low acts as stall.
REQ-011 out_data  output  NCH*WIDTH  registered entry, same channel packing as in_data.
REQ-012 count  output  2  number of entries held (0..2).

Function
REQ-013 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-014 Storage: main register M drives out_data directly; skid register S exists only with the skid feature enabled.
REQ-015 States: EMPTY (count=0), ONE (M valid, count=1), TWO (M and S valid, count=2); out_valid = (state != EMPTY).
REQ-016 EMPTY: input transfer -> ONE, M <= in_data; otherwise remain EMPTY.
REQ-017 ONE: input and output transfer -> ONE, M <= in_data; output only -> EMPTY; input only -> TWO, S <= in_data; neither -> hold.
REQ-018 TWO: output transfer -> ONE, M <= S; otherwise hold; in_ready is 0, so no input is accepted.
REQ-019 Ordering: entries leave in exact acceptance order; no entry is duplicated or dropped except by flush or rst.
REQ-020 Latency: an entry accepted at edge N is visible on out_data after edge N with out_valid=1 (one cycle), unless older entries are held.
REQ-021 When not transferring, M and S hold value; out_data is stable while out_valid && !out_ready.
REQ-022 flush has priority over all transfers: next state EMPTY, count 0, out_valid 0; an input accepted in the flush cycle is discarded; M/S contents are don't-care but not X.
REQ-023 All NCH channels update together; there is no per-channel enable.

Reset
REQ-024 While rst is high: state EMPTY, out_valid 0, count 0, M and S all zero, out_data all zero.
REQ-025 in_ready is 1 during and after reset (skid enabled); an entry in flight when rst asserts is lost.
REQ-026 First input transfer is possible on the first clk edge after rst deasserts.

Configuration
REQ-027 Macro PIPE_STAGE_REG_SKID_EN selects the skid buffer.
REQ-028 Defined: S present, state TWO reachable, in_ready = registered (state != TWO), with no combinational path from out_ready to in_ready; full throughput of one entry per cycle.
REQ-029 Undefined: S and state TWO absent, count never exceeds 1, in_ready = !out_valid || out_ready (combinational); ONE with input and no output holds, since in_ready is 0.
REQ-030 Port list, reset values and REQ-016/017 (except the TWO branch) are identical in both builds.

Verification
REQ-031 Reset, then in_valid=1 with in_data={16'h1234,16'hABCD} and out_ready=1 -> after 1 edge out_valid=1, out_data=32'h1234ABCD, count=1.
REQ-032 Stream 1,2,3,4 with out_ready=1 continuously -> outputs 1,2,3,4 on consecutive cycles, in_ready constantly 1.
REQ-033 Skid build, out_ready=0, offer 5,6,7 -> 5 and 6 accepted, count=2, in_ready=0, 7 held upstream; raise out_ready -> outputs 5,6,7 in order.
REQ-034 Count=2 with flush=1 and in_valid=1 (data 9) -> next cycle out_valid=0, count=0, in_ready=1; 9 never appears on the output.
REQ-035 rst asserted mid-stream at count=2 -> outputs zero immediately (asynchronous), count=0; after release a new entry 8'h42 emerges alone.
REQ-036 Non-skid build, out_ready toggling 1,0,1,0 with continuous input -> no loss or duplication; in_ready follows !out_valid || out_ready every cycle.
